// File: rtl/fft_agu_pkg.sv
// Shared types and helpers for the radix-2 FFT butterfly address generator.
package fft_agu_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StFin  = 2'd2
   } agu_state_e;

   // Smallest stage-index width able to hold the value awl.
   function automatic int unsigned swl_from_awl(input int unsigned awl);
      return $clog2(awl + 1);
   endfunction

   // Left shift that scales a stage-local twiddle index onto the full-size ROM.
   function automatic int unsigned tw_shift(input int unsigned awl, input int unsigned stg);
      return awl - 1 - stg;
   endfunction

endpackage

// File: rtl/onehot_stage_reg.sv
// One-hot butterfly span register: resets and loads to 1, shifts left per stage.
module onehot_stage_reg #(
   parameter int unsigned W = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_one,
   input  logic         shift,
   output logic [W-1:0] q
);

   // Span register; load_one wins over shift.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= W'(1);
      end else if (load_one) begin
         q <= W'(1);
      end else if (shift) begin
         q <= {q[W-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/fft_butterfly_agu.sv
// Self-sequencing operand/twiddle address generator for an in-place radix-2 FFT.
module fft_butterfly_agu
   import fft_agu_pkg::*;
#(
   parameter int unsigned AWL = 5,
   parameter int unsigned SWL = swl_from_awl(AWL)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [SWL-1:0] cfg_log2n,
   input  logic           ready,
   output logic           valid,
   output logic [AWL-1:0] a_addr,
   output logic [AWL-1:0] b_addr,
   output logic [AWL-2:0] tw_addr,
   output logic [SWL-1:0] stage,
   output logic           last_in_stage,
   output logic           busy,
   output logic           done
);

   agu_state_e     state_q, state_d;
   logic [AWL-1:0] addr_q, addr_d;
   logic [SWL-1:0] stage_q, stage_d;
   logic [AWL-2:0] cnt_q, cnt_d;
   logic [SWL-1:0] n_q, n_d;
   logic [AWL-1:0] lay;

   logic           run;
   logic           start_acc;
   logic           xfer;
   logic           last_beat;
   logic           last_stage;
   logic           stage_adv;
   logic [SWL-1:0] n_in;
   logic [AWL-1:0] n_mask;
   logic [AWL-2:0] last_cnt;
   logic [AWL-1:0] addr_inc;
   logic [AWL-2:0] tw_v;

   onehot_stage_reg #(
      .W (AWL)
   ) u_lay (
      .clk      (clk),
      .rst      (rst),
      .load_one (start_acc),
      .shift    (stage_adv),
      .q        (lay)
   );

   // Decode of the current position within the run.
   always_comb begin
      run        = (state_q == StRun);
      start_acc  = (state_q == StIdle) && start;
      xfer       = run && ready;
      n_in       = (cfg_log2n > SWL'(AWL)) ? SWL'(AWL) : cfg_log2n;
      // Shifting all-ones by n (up to AWL) leaves exactly the low n bits set after inversion.
      n_mask     = ~({AWL{1'b1}} << n_q);
      last_cnt   = ~({(AWL-1){1'b1}} << (n_q - SWL'(1)));
      last_beat  = run && (cnt_q == last_cnt);
      last_stage = (stage_q == (n_q - SWL'(1)));
      stage_adv  = xfer && last_beat && !last_stage;
      // Next A: bump B and clear the span bit, which skips all addresses with that bit set.
      addr_inc   = (~lay & ((addr_q | lay) + AWL'(1))) & n_mask;
      tw_v       = (AWL-1)'((addr_q & (lay - AWL'(1))) << tw_shift(AWL, 32'(stage_q)));
   end

   // FSM next state.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = (n_in == '0) ? StFin : StRun;
            end
         end
         StRun: begin
            if (xfer && last_beat && last_stage) begin
               state_d = StFin;
            end
         end
         StFin:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Datapath next state: address, stage and butterfly counters, latched order.
   always_comb begin
      addr_d  = addr_q;
      stage_d = stage_q;
      cnt_d   = cnt_q;
      n_d     = n_q;
      if (start_acc) begin
         n_d     = n_in;
         addr_d  = '0;
         stage_d = '0;
         cnt_d   = '0;
      end else if (xfer) begin
         if (!last_beat) begin
            addr_d = addr_inc;
            cnt_d  = cnt_q + (AWL-1)'(1);
         end else if (!last_stage) begin
            addr_d  = '0;
            stage_d = stage_q + SWL'(1);
            cnt_d   = '0;
         end
      end
   end

   // State registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         addr_q  <= '0;
         stage_q <= '0;
         cnt_q   <= '0;
         n_q     <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         stage_q <= stage_d;
         cnt_q   <= cnt_d;
         n_q     <= n_d;
      end
   end

   // Outputs; beat fields are forced to zero outside RUN.
   always_comb begin
      valid         = run;
      busy          = run;
      done          = (state_q == StFin);
      last_in_stage = last_beat;
      a_addr        = run ? addr_q : '0;
      b_addr        = run ? (addr_q | lay) : '0;
      tw_addr       = run ? tw_v : '0;
      stage         = run ? stage_q : '0;
   end

endmodule

// File: tb/tb_fft_butterfly_agu.sv
// Randomized self-checking bench for fft_butterfly_agu against a butterfly-order model.
module tb_fft_butterfly_agu;

   localparam int unsigned AWL = 5;
   localparam int unsigned SWL = 3;
   localparam int unsigned EW  = 3 * AWL - 1 + SWL + 1;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           start = 1'b0;
   logic [SWL-1:0] cfg_log2n = '0;
   logic           ready = 1'b0;
   logic           valid;
   logic [AWL-1:0] a_addr;
   logic [AWL-1:0] b_addr;
   logic [AWL-2:0] tw_addr;
   logic [SWL-1:0] stage;
   logic           last_in_stage;
   logic           busy;
   logic           done;

   int checks = 0;
   int errors = 0;

   logic [EW-1:0] exp_q[$];

   fft_butterfly_agu #(
      .AWL (AWL),
      .SWL (SWL)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .cfg_log2n     (cfg_log2n),
      .ready         (ready),
      .valid         (valid),
      .a_addr        (a_addr),
      .b_addr        (b_addr),
      .tw_addr       (tw_addr),
      .stage         (stage),
      .last_in_stage (last_in_stage),
      .busy          (busy),
      .done          (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s got %h want %h", tag, obs, want);
      end
   endtask

   // Butterflies of stage s, in order: every address with bit s clear, ascending.
   task automatic build_model(input int n);
      exp_q.delete();
      for (int s = 0; s < n; s++) begin
         for (int j = 0; j < (1 << (n - 1)); j++) begin
            int lo, a, b, tw;
            bit last;
            lo   = j % (1 << s);
            a    = ((j - lo) * 2) + lo;
            b    = a + (1 << s);
            tw   = lo * (1 << (AWL - 1 - s));
            last = (j == (1 << (n - 1)) - 1);
            exp_q.push_back({AWL'(a), AWL'(b), (AWL-1)'(tw), SWL'(s), last});
         end
      end
   endtask

   // Called at a negedge; starts a run and follows it through DONE and back to IDLE.
   task automatic run_n(input int cfg, input bit rnd_ready, input bit noise);
      int n_eff, idx, guard, total;
      bit rdy;
      n_eff = (cfg > int'(AWL)) ? int'(AWL) : cfg;
      build_model(n_eff);
      total = exp_q.size();
      cfg_log2n = SWL'(cfg);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      idx = 0;
      guard = 0;
      while (idx < total && guard < 4000) begin
         chk($sformatf("valid_busy n=%0d beat%0d", cfg, idx), {30'd0, valid, busy}, 32'd3);
         chk($sformatf("beat n=%0d idx%0d", cfg, idx),
             32'({a_addr, b_addr, tw_addr, stage, last_in_stage}), 32'(exp_q[idx]));
         chk($sformatf("no_done n=%0d beat%0d", cfg, idx), 32'(done), 32'd0);
         rdy = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         ready = rdy;
         if (noise) begin
            start = 1'($urandom);
            cfg_log2n = SWL'($urandom);
         end
         @(negedge clk);
         if (rdy) idx++;
         guard++;
      end
      start = 1'b0;
      ready = 1'b0;
      chk($sformatf("beat_count n=%0d", cfg), 32'(idx), 32'(total));
      chk($sformatf("fin n=%0d", cfg), {29'd0, done, valid, busy}, 32'd4);
      chk($sformatf("fin_addr n=%0d", cfg), 32'({a_addr, b_addr, tw_addr, stage}), 32'd0);
      @(negedge clk);
      chk($sformatf("idle n=%0d", cfg), {29'd0, done, valid, busy}, 32'd0);
   endtask

   initial begin
      #1;
      chk("reset_outs", {16'd0, a_addr, b_addr, tw_addr, stage, last_in_stage},
          32'd0);
      chk("reset_ctrl", {29'd0, valid, busy, done}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      run_n(3, 1'b0, 1'b0);
      run_n(5, 1'b0, 1'b0);
      run_n(3, 1'b1, 1'b0);
      run_n(0, 1'b0, 1'b0);
      run_n(7, 1'b0, 1'b0);
      run_n(1, 1'b1, 1'b0);

      // Abort mid-stage-1 with an asynchronous reset.
      cfg_log2n = 3'd3;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      ready = 1'b1;
      repeat (5) @(negedge clk);
      chk("pre_rst_stage", 32'(stage), 32'd1);
      chk("pre_rst_a", 32'(a_addr), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_ctrl", {29'd0, valid, busy, done}, 32'd0);
      chk("async_rst_addr", 32'({a_addr, b_addr, tw_addr, stage}), 32'd0);
      ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run_n(3, 1'b0, 1'b0);

      // START pulses and order changes during the run must be ignored.
      run_n(4, 1'b1, 1'b1);
      run_n(5, 1'b1, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fft_butterfly_agu.md
# fft_butterfly_agu

Self-sequencing address generator for the in-place radix-2 iterative FFT engine. One START runs every stage of a 2^n-point transform (n selectable per run, up to 2^AWL). Each beat it issues the butterfly operand pair A/B, the twiddle ROM index and stage tags, with VALID/READY backpressure toward the butterfly datapath. DONE pulses when the last butterfly is accepted.

## Interface
- AWL, default 5: data address width; maximum transform size is 2^AWL points.
- SWL, default 3: stage-index width; must satisfy 2^SWL > AWL.
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  run request; sampled only in IDLE.
- CFG_LOG2N  in  SWL  transform order n; latched on an accepted START.
- READY  in  1  datapath accepts the current beat.
- VALID  out  1  A/B/TW/STAGE outputs are valid.
- A_ADDR  out  AWL  upper-less operand address.
- B_ADDR  out  AWL  partner address, A_ADDR | 2^stage.
- TW_ADDR  out  AWL-1  twiddle index into a 2^(AWL-1)-entry W_(2^AWL) ROM.
- STAGE  out  SWL  current stage, 0..n-1.
- LAST_IN_STAGE  out  1  current beat is the final butterfly of its stage.
- BUSY  out  1  high in RUN.
- DONE  out  1  one-cycle completion pulse.

## Operation
- FSM has three states: IDLE, RUN and FIN.
  - IDLE to RUN on START, when the latched n is in 1..AWL.
  - IDLE to FIN on START with n = 0, giving an immediate DONE and no beats.
  - Any n > AWL is clamped to AWL.
  - RUN to FIN on a transfer of the last butterfly of stage n-1.
  - FIN to IDLE unconditionally after one cycle.
- State registers:
  - addr (AWL bits)
  - one-hot lay (AWL bits; reset and start value 1)
  - stage counter
  - butterfly counter (AWL-1 bits)
  - latched n
- Combinational outputs from the state registers:
  - A = addr.
  - B = addr | lay.
  - TW = (addr & (lay-1)) << (AWL-1-stage), truncated to AWL-1 bits.
  - TW is independent of n because the ROM is always sized for 2^AWL points.
- A transfer is VALID & READY. With VALID & !READY, every output holds.
- On a transfer that is not last-in-stage:
  - addr <= ~lay & (B+1), masked to the low n bits.
  - The butterfly counter increments.
- On a transfer that is last-in-stage (counter = 2^(n-1)-1) and not the last stage:
  - addr <= 0.
  - lay <= lay << 1.
  - stage increments and the counter clears.
- Address bits at or above n are always 0.
- START in RUN or FIN is ignored, and CFG_LOG2N changes during a run have no effect.
- RST at any time forces the reset state immediately: IDLE, addr 0, lay 1, counters 0, n 0.
- Each stage issues 2^(n-1) beats, so a run issues n·2^(n-1) beats in total.

## Timing
- Reset values of all outputs:
  - A_ADDR, B_ADDR and TW_ADDR are 0; B_ADDR is 0 because B is gated to 0 outside RUN.
  - STAGE 0, VALID 0, LAST_IN_STAGE 0, BUSY 0, DONE 0.
- Outside RUN, A_ADDR, B_ADDR, TW_ADDR and STAGE are driven 0.
- START is sampled at edge k. VALID and BUSY are high from cycle k+1, and the first beat is A=0, B=1, TW=0.
- With READY held high, one beat is issued per cycle with no bubbles, including across stage boundaries.
- The last transfer is at edge m. Then:
  - FIN and DONE occur in cycle m+1, with VALID and BUSY low.
  - The block is back in IDLE in cycle m+2.
  - A new START is accepted at the edge ending cycle m+2 at the earliest.
- VALID never drops while the block is in RUN, regardless of READY.

## Structure
- Shared package `fft_agu_pkg` holds:
  - FSM state encoding (IDLE/RUN/FIN, 2 bits)
  - an SWL-from-AWL helper constant function
  - the twiddle-shift helper
- One natural sub-module, `onehot_stage_reg`:
  - parametrised width
  - asynchronous reset to 1
  - load-1 and shift-left enables
  - holds lay

## Test plan
- AWL=5, n=3, READY=1. The bench must see 12 consecutive beats:
  - stage 0: (0,1),(2,3),(4,5),(6,7), TW all 0.
  - stage 1: (0,2),(1,3),(4,6),(5,7), TW 0,8,0,8.
  - stage 2: (0,4),(1,5),(2,6),(3,7), TW 0,4,8,12.
  - DONE one cycle after the 12th beat.
- n=5 full size: 80 beats. The final beat is (15,31), TW=15, STAGE=4 and LAST_IN_STAGE=1.
- n=3 with READY toggling pseudo-randomly: the beat sequence matches scenario 1, and outputs are stable whenever READY=0.
- START with n=0 gives a DONE pulse 1 cycle later with no VALID. START with n=7 under AWL=5 behaves as n=5.
- RST asserted mid-stage-1 asynchronously clears VALID, BUSY and the addresses to 0. A subsequent START restarts from (0,1).
- START pulses during RUN are ignored, and CFG_LOG2N changes during RUN do not alter the beat count.
